// File: rtl/parity_engine.sv
`default_nettype none
// ============================================================================
// parity_engine : serial, frame-aware UART parity generator / checker
// Rev 1.0
// ============================================================================
module parity_engine #(
  parameter int MIN_DATA_W = 5,
  parameter int MAX_DATA_W = 9,
  parameter int NUM_W      = $clog2(MAX_DATA_W - MIN_DATA_W + 1),
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [NUM_W-1:0] data_bit_num_i,
  input  logic [1:0]       parity_mode_i,
  input  logic             check_mode_i,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic             clr_err_i,
  output logic             busy_o,
  output logic             parity_valid_o,
  output logic             parity_bit_o,
  output logic             check_done_o,
  output logic             parity_err_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int               LEN_W  = $clog2(MAX_DATA_W + 1);
  localparam logic [NUM_W-1:0] C_SPAN = NUM_W'(MAX_DATA_W - MIN_DATA_W);
  localparam logic [LEN_W-1:0] C_MIN  = LEN_W'(MIN_DATA_W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_GEN  = 3'd2,
    S_PAR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [1:0]       mode_q;
  logic             chk_q;
  logic             acc_q;
  logic             mis_q;
  logic             pbit_q;
  logic             sticky_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic [NUM_W-1:0] num_d;
  logic [LEN_W-1:0] len_d;
  logic             acc_d;
  logic             last_bit_d;

  function automatic logic exp_parity(input logic [1:0] mode, input logic acc);
    logic r;
    unique case (mode)
      2'b00:   r = acc;
      2'b01:   r = ~acc;
      2'b10:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Out-of-range length selects saturate at the widest supported frame.
  assign num_d      = (data_bit_num_i > C_SPAN) ? C_SPAN : data_bit_num_i;
  assign len_d      = C_MIN + LEN_W'(num_d);
  assign acc_d      = acc_q ^ bit_i;
  assign last_bit_d = ((cnt_q + LEN_W'(1)) == len_q);

  // A restart during GEN/DONE swallows the pulse of that cycle.
  assign busy_o         = (state_q != S_IDLE);
  assign parity_valid_o = (state_q == S_GEN) & ~start_i;
  assign check_done_o   = (state_q == S_DONE) & ~start_i;
  assign parity_err_o   = (state_q == S_DONE) & mis_q & ~start_i;
  assign parity_bit_o   = pbit_q;
  assign err_sticky_o   = sticky_q;
  assign err_cnt_o      = err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 2'b00;
      chk_q     <= 1'b0;
      acc_q     <= 1'b0;
      mis_q     <= 1'b0;
      pbit_q    <= 1'b0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      // Clear-then-count when a clear coincides with an error pulse.
      if (parity_err_o) begin
        sticky_q <= 1'b1;
        if (clr_err_i)
          err_cnt_q <= CNT_W'(1);
        else if (err_cnt_q != {CNT_W{1'b1}})
          err_cnt_q <= err_cnt_q + CNT_W'(1);
      end else if (clr_err_i) begin
        sticky_q  <= 1'b0;
        err_cnt_q <= '0;
      end

      if (start_i) begin
        state_q <= S_DATA;
        len_q   <= len_d;
        mode_q  <= parity_mode_i;
        chk_q   <= check_mode_i;
        cnt_q   <= '0;
        acc_q   <= 1'b0;
        mis_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_DATA: begin
            if (bit_valid_i) begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + LEN_W'(1);
              if (last_bit_d) begin
                state_q <= chk_q ? S_PAR : S_GEN;
                if (!chk_q)
                  pbit_q <= exp_parity(mode_q, acc_d);
              end
            end
          end
          S_GEN:  state_q <= S_IDLE;
          S_PAR: begin
            if (bit_valid_i) begin
              mis_q   <= (bit_i != exp_parity(mode_q, acc_q));
              state_q <= S_DONE;
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/parity_engine.md
Name: parity_engine

Overview:
Serial, frame-aware parity generator/checker for the UART datapath. Per-bit it consumes the same bit stream that the TX shifter emits or the RX sampler produces. It accumulates parity over a runtime-selected data length, then either emits the parity bit (generate mode) or compares the received parity bit (check mode). Check mode also maintains a sticky error flag and a saturating error counter for the status register.

Parameters:
MIN_DATA_W, 5, smallest supported data length in bits
MAX_DATA_W, 9, largest supported data length in bits (MAX_DATA_W >= MIN_DATA_W)
NUM_W, $clog2(MAX_DATA_W-MIN_DATA_W+1), width of the data-length select
CNT_W, 8, width of the parity error counter

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous, active-high reset
start_i  in  1  begin a frame; latches data_bit_num_i, parity_mode_i, check_mode_i
data_bit_num_i  in  NUM_W  data bits = MIN_DATA_W + value; values above MAX_DATA_W-MIN_DATA_W clamp to MAX_DATA_W
parity_mode_i  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
check_mode_i  in  1  0 generate (TX), 1 check (RX)
bit_valid_i  in  1  bit_i is valid this cycle
bit_i  in  1  serial data bit, LSB first; in check mode also carries the received parity bit
clr_err_i  in  1  clears err_sticky_o and err_cnt_o
busy_o  out  1  frame in progress
parity_valid_o  out  1  one-cycle pulse; parity_bit_o valid (generate mode only)
parity_bit_o  out  1  computed parity bit; holds its last value between pulses
check_done_o  out  1  one-cycle pulse; received parity evaluated (check mode only)
parity_err_o  out  1  one-cycle pulse, coincident with check_done_o, on mismatch
err_sticky_o  out  1  set on any mismatch; cleared by clr_err_i or reset
err_cnt_o  out  CNT_W  count of mismatches, saturating at all-ones

Behaviour:
- Reset: state IDLE; accumulator 0; bit count 0; all outputs 0.
- States:
  - IDLE: bit_valid_i ignored. start_i goes to DATA, latches the configuration, clears the accumulator and the bit count.
  - DATA: each bit_valid_i cycle does acc ^= bit_i and cnt++. When the accepted bit is number N (N = latched length), the next state is GEN (generate mode) or PAR (check mode).
  - GEN: lasts one cycle. parity_valid_o=1; parity_bit_o = expected parity. Then IDLE.
  - PAR: waits for bit_valid_i. On that bit, registers mismatch = (bit_i != expected). Then DONE.
  - DONE: lasts one cycle. check_done_o=1; parity_err_o=mismatch. Then IDLE.
- Expected parity:
  - even = acc, so the total count of ones including the parity bit is even;
  - odd = ~acc;
  - mark = 1;
  - space = 0.
- Latency: the parity_valid_o pulse occurs in the cycle after the last data bit is accepted. check_done_o occurs in the cycle after the parity bit is accepted.
- Gaps of any length between bit_valid_i cycles are allowed; no timeout.
- busy_o=1 in DATA, GEN, PAR and DONE; busy_o=0 only in IDLE.
- start_i while busy (any non-IDLE state): aborts the frame silently (no parity_valid_o, check_done_o or error), restarts in DATA with the new configuration. start_i in GEN or DONE suppresses that cycle's pulse.
- start_i and bit_valid_i in the same cycle: start wins; the bit is discarded.
- Configuration inputs are sampled only on start_i; mid-frame changes have no effect.
- Error counter: increments on parity_err_o and saturates at 2^CNT_W-1.
- clr_err_i coincident with an error pulse: clear then count, giving err_cnt_o=1 and err_sticky_o=1.
- Reset mid-frame: returns to IDLE next edge; no pulses emitted.

Test Plan:
- Generate, 8 bits (num=3), even, data 0xA7 LSB first -> parity_valid_o one cycle after the 8th bit; parity_bit_o=1; busy_o falls on the following cycle.
- Generate, 5 bits (num=0), odd, data 0x13 (bits 1,1,0,0,1); then 9 bits (num=4), mark, data 0x000 -> first frame parity_bit_o=0; second frame parity_bit_o=1.
- Check, 7 bits, even, data 0x55 (four ones), parity bit 1 -> check_done_o=1, parity_err_o=1, err_sticky_o=1, err_cnt_o=1. Repeat with parity bit 0 -> no error, count unchanged.
- Abort: start frame, send 3 bits, assert start_i again, send a full 8-bit frame 0x01 with even parity -> exactly one parity_valid_o, parity_bit_o=1.
- Saturation with CNT_W=2: 5 erroneous check frames -> err_cnt_o=3. Then clr_err_i coincident with a 6th error -> err_cnt_o=1, err_sticky_o=1.
- Reset mid-PAR (rst_i high one cycle) -> all outputs 0, busy_o=0. A following parity bit_valid_i is ignored; no check_done_o.
